// File: rtl/axis_route_xbar.sv
// axis_route_xbar: AXI-Stream crossbar; each output picks one input (or none) from a runtime config, with broadcast and drain-safe reconfig.
module axis_route_xbar #(
  parameter int NUM_IN = 5,
  parameter int NUM_OUT = 8,
  parameter int DATA_W = 1536,
  parameter int DROP_UNROUTED = 0,
  localparam int SEL_W = $clog2(NUM_IN + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_OUT*SEL_W-1:0]  ctrl,
  input  logic                      ctrl_load,
  output logic                      ctrl_busy,
  input  logic [NUM_IN*DATA_W-1:0]  s_tdata,
  input  logic [NUM_IN-1:0]         s_tlast,
  input  logic [NUM_IN-1:0]         s_tvalid,
  output logic [NUM_IN-1:0]         s_tready,
  output logic [NUM_OUT*DATA_W-1:0] m_tdata,
  output logic [NUM_OUT-1:0]        m_tlast,
  output logic [NUM_OUT-1:0]        m_tvalid,
  input  logic [NUM_OUT-1:0]        m_tready
);
  logic [NUM_OUT*SEL_W-1:0] cfg_q, pend_q;
  logic busy_q, apply;
  logic [NUM_IN-1:0][NUM_OUT-1:0] dst, ld, done_q, done_d;
  logic [NUM_IN-1:0] hold;
  logic [NUM_OUT-1:0] can_load, m_ld, m_lin, m_tlast_q, m_tvalid_q;
  logic [NUM_OUT-1:0][DATA_W-1:0] m_din, m_tdata_q;

  // while a config is pending, only inputs with a partially delivered beat may progress
  always_comb begin
    dst = '0;
    ld = '0;
    hold = '0;
    m_ld = '0;
    m_din = '0;
    m_lin = '0;
    s_tready = '0;
    done_d = done_q;
    can_load = ~m_tvalid_q | m_tready;
    for (int i = 0; i < NUM_IN; i++) begin
      for (int j = 0; j < NUM_OUT; j++) dst[i][j] = cfg_q[j*SEL_W +: SEL_W] == SEL_W'(i + 1);
      hold[i] = busy_q & ~|done_q[i];
      ld[i] = {NUM_OUT{s_tvalid[i] & ~hold[i]}} & dst[i] & ~done_q[i] & can_load;
      s_tready[i] = rst_n & ~hold[i] & (|dst[i] ? &(done_q[i] | ld[i] | ~dst[i]) : (DROP_UNROUTED != 0));
      done_d[i] = (s_tvalid[i] & s_tready[i]) ? '0 : done_q[i] | ld[i];
      m_ld = m_ld | ld[i];
      for (int j = 0; j < NUM_OUT; j++) begin
        m_din[j] = dst[i][j] ? s_tdata[i*DATA_W +: DATA_W] : m_din[j];
        m_lin[j] = dst[i][j] ? s_tlast[i] : m_lin[j];
      end
    end
    apply = busy_q & ~|done_q & ~|m_tvalid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q <= '0;
      pend_q <= '0;
      busy_q <= 1'b0;
      done_q <= '0;
      m_tvalid_q <= '0;
      m_tdata_q <= '0;
      m_tlast_q <= '0;
    end else begin
      if (ctrl_load) pend_q <= ctrl;
      busy_q <= ctrl_load | (busy_q & ~apply);
      if (apply) cfg_q <= pend_q;
      done_q <= done_d;
      m_tvalid_q <= m_ld | (m_tvalid_q & ~m_tready);
      for (int j = 0; j < NUM_OUT; j++) begin
        m_tdata_q[j] <= m_ld[j] ? m_din[j] : m_tdata_q[j];
        m_tlast_q[j] <= m_ld[j] ? m_lin[j] : m_tlast_q[j];
      end
    end
  end

  assign ctrl_busy = busy_q;
  assign m_tdata = m_tdata_q;
  assign m_tlast = m_tlast_q;
  assign m_tvalid = m_tvalid_q;
endmodule

// File: tb/tb_axis_route_xbar.sv
// tb_axis_route_xbar: directed scoreboard bench for axis_route_xbar (5 in, 8 out, 16-bit lanes).
module tb_axis_route_xbar;
  localparam int NI = 5, NO = 8, DW = 16, SW = 3;
  logic clk = 1'b0, rst_n = 1'b0, ctrl_load = 1'b0;
  logic [NO*SW-1:0] ctrl = '0;
  logic [NI*DW-1:0] s_tdata = '0;
  logic [NI-1:0] s_tlast = '0, s_tvalid = '0, s_tready, s_tready1;
  logic [NO-1:0] m_tready = '1, m_tlast, m_tvalid, m_tlast1, m_tvalid1;
  logic [NO*DW-1:0] m_tdata, m_tdata1;
  logic ctrl_busy, ctrl_busy1;
  int n_assert = 0, n_fail = 0;
  logic [DW:0] sb[NO][$];

  axis_route_xbar #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .DROP_UNROUTED(0)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .ctrl_load(ctrl_load), .ctrl_busy(ctrl_busy),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready));

  axis_route_xbar #(.NUM_IN(NI), .NUM_OUT(NO), .DATA_W(DW), .DROP_UNROUTED(1)) dut_drop (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .ctrl_load(ctrl_load), .ctrl_busy(ctrl_busy1),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready1),
    .m_tdata(m_tdata1), .m_tlast(m_tlast1), .m_tvalid(m_tvalid1), .m_tready(m_tready));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lane(input int i, input logic [DW-1:0] d, input logic l);
    s_tdata[i*DW +: DW] = d;
    s_tlast[i] = l;
  endtask

  task automatic push(input logic [NO-1:0] m, input logic [DW-1:0] d, input logic l);
    for (int j = 0; j < NO; j++) if (m[j]) sb[j].push_back({l, d});
  endtask

  task automatic load_cfg(input logic [NO*SW-1:0] c);
    ctrl = c;
    ctrl_load = 1'b1;
    @(posedge clk); #1;
    ctrl_load = 1'b0;
    chk("cfg_busy", 32'(ctrl_busy), 32'd1);
    for (int c2 = 0; c2 < 30 && ctrl_busy; c2++) begin
      @(posedge clk); #1;
    end
    chk("cfg_apply", 32'(ctrl_busy), 32'd0);
  endtask

  task automatic wait_acc(input logic [NI-1:0] m, input string tag);
    logic [NI-1:0] acc;
    for (int c = 0; c < 30 && |(s_tvalid & m); c++) begin
      @(negedge clk);
      acc = s_tvalid & s_tready & m;
      @(posedge clk); #1;
      s_tvalid = s_tvalid & ~acc;
    end
    chk(tag, 32'(s_tvalid & m), 32'd0);
    s_tvalid = s_tvalid & ~m;
  endtask

  task automatic clear_sb();
    for (int j = 0; j < NO; j++) sb[j].delete();
  endtask

  function automatic int sb_total();
    int t = 0;
    for (int j = 0; j < NO; j++) t += sb[j].size();
    return t;
  endfunction

  // every beat leaving an output must be the oldest expected beat for that output
  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < NO; j++) begin
        if (m_tvalid[j] & m_tready[j]) begin
          if (sb[j].size() == 0) chk($sformatf("m%0d_extra_beat", j), 32'(sb[j].size()), 32'd1);
          else chk($sformatf("m%0d_beat", j), 32'({m_tlast[j], m_tdata[j*DW +: DW]}), 32'(sb[j].pop_front()));
        end
      end
    end
  end

  initial begin
    // reset
    s_tvalid = '1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", m_tdata[31:0], 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_ctrl_busy", 32'(ctrl_busy), 32'd0);
    @(posedge clk); #1;
    s_tvalid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // straight map, out j <- in (j%5)
    load_cfg(24'o32154321);
    for (int k = 0; k < 10; k++) begin
      s_tvalid = '1;
      for (int i = 0; i < NI; i++) lane(i, 16'(k), k == 9);
      push('1, 16'(k), k == 9);
      @(negedge clk);
      chk("t2_s_tready", 32'(s_tready), 32'h1f);
      if (k > 0) chk("t2_no_bubble", 32'(m_tvalid), 32'hff);
      @(posedge clk); #1;
    end
    s_tvalid = '0;
    s_tlast = '0;
    @(negedge clk);
    chk("t2_last_valid", 32'(m_tvalid), 32'hff);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_idle", 32'(m_tvalid), 32'd0);
    chk("t2_drained", 32'(sb_total()), 32'd0);
    @(posedge clk); #1;

    // broadcast in0 -> outs 0,1,2 with out1 stalled
    load_cfg(24'o00000111);
    m_tready = 8'hfd;
    s_tvalid = 5'b00001;
    lane(0, 16'h1111, 1'b0);
    push(8'h07, 16'h1111, 1'b0);
    @(negedge clk);
    chk("t3_first_accept", 32'(s_tready[0]), 32'd1);
    @(posedge clk); #1;
    lane(0, 16'ha5a5, 1'b1);
    push(8'h07, 16'ha5a5, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_stall", 32'(s_tready[0]), 32'd0);
      if (c == 2) chk("t3_once", 32'(m_tvalid & 8'h05), 32'd0);
      @(posedge clk); #1;
    end
    m_tready = '1;
    @(negedge clk);
    chk("t3_release", 32'(s_tready[0]), 32'd1);
    @(posedge clk); #1;
    lane(0, 16'h5a5a, 1'b0);
    push(8'h07, 16'h5a5a, 1'b0);
    @(negedge clk);
    chk("t3_next_beat", 32'(s_tready[0]), 32'd1);
    @(posedge clk); #1;
    s_tvalid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_drained", 32'(sb_total()), 32'd0);

    // unrouted input: stall vs drop
    load_cfg('0);
    s_tvalid = 5'b01000;
    lane(3, 16'hdead, 1'b1);
    @(negedge clk);
    chk("t4_stall", 32'(s_tready[3]), 32'd0);
    chk("t4_drop", 32'(s_tready1[3]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_no_out", 32'(m_tvalid), 32'd0);
    chk("t4_no_out_drop", 32'(m_tvalid1), 32'd0);
    @(posedge clk); #1;
    s_tvalid = '0;

    // reconfig while out0 holds a beat: A = out0<-in0, out2<-in2; B = out3<-in0, out4<-in2
    load_cfg(24'o00000301);
    m_tready = 8'hfe;
    s_tvalid = 5'b00001;
    lane(0, 16'h0b01, 1'b1);
    push(8'h01, 16'h0b01, 1'b1);
    @(negedge clk);
    chk("t5_first", 32'(s_tready[0]), 32'd1);
    @(posedge clk); #1;
    lane(0, 16'h0b02, 1'b1);
    push(8'h08, 16'h0b02, 1'b1);
    ctrl = 24'o00031000;
    ctrl_load = 1'b1;
    @(negedge clk);
    chk("t5_blocked", 32'(s_tready[0]), 32'd0);
    @(posedge clk); #1;
    ctrl_load = 1'b0;
    s_tvalid[2] = 1'b1;
    lane(2, 16'hc001, 1'b1);
    push(8'h10, 16'hc001, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t5_busy", 32'(ctrl_busy), 32'd1);
      chk("t5_hold", 32'(s_tready & 5'b00101), 32'd0);
      @(posedge clk); #1;
    end
    m_tready = '1;
    wait_acc(5'b00101, "t5_accept_timeout");
    chk("t5_applied", 32'(ctrl_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_zero_loss", 32'(sb_total()), 32'd0);

    // reset in the middle of a broadcast (out2 stalled, outs 0,1 already took beat 2)
    load_cfg(24'o00000111);
    m_tready = 8'hfb;
    s_tvalid = 5'b00001;
    lane(0, 16'h6001, 1'b0);
    push(8'h07, 16'h6001, 1'b0);
    @(negedge clk);
    chk("t6_first", 32'(s_tready[0]), 32'd1);
    @(posedge clk); #1;
    lane(0, 16'h6002, 1'b1);
    @(negedge clk);
    chk("t6_partial", 32'(s_tready[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_sb();
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_rst_s_tready", 32'(s_tready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_tready = '1;
    @(negedge clk);
    chk("t6_cfg_cleared", 32'(s_tready[0]), 32'd0);
    chk("t6_busy_cleared", 32'(ctrl_busy), 32'd0);
    chk("t6_out_idle", 32'(m_tvalid), 32'd0);
    @(posedge clk); #1;
    s_tvalid = '0;
    load_cfg(24'o00000111);
    s_tvalid = 5'b00001;
    lane(0, 16'h6003, 1'b1);
    push(8'h07, 16'h6003, 1'b1);
    wait_acc(5'b00001, "t6_accept_timeout");
    repeat (4) @(posedge clk);
    #1;
    chk("final_drained", 32'(sb_total()), 32'd0);
    chk("final_idle", 32'(m_tvalid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
